// File: rtl/calc_multi_port.sv
// calc_multi_port: NUM_PORTS request/response ports sharing one DATA_W-bit ALU through a round-robin arbiter.
// Define CALC_SHIFT_EN to build the shifter (commands 5/6); without it those commands answer as invalid.
module calc_multi_port #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
  input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
  output logic [2*NUM_PORTS-1:0]      out_resp,
  output logic [DATA_W*NUM_PORTS-1:0] out_data
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
`ifdef CALC_SHIFT_EN
  localparam int         SH_W    = $clog2(DATA_W);
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;
`endif

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_OVF = 2'd2;
  localparam logic [1:0] RESP_INV = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    PENDING,
    EXEC
  } port_state_t;

  port_state_t       state_q [NUM_PORTS];
  port_state_t       state_d [NUM_PORTS];
  logic [3:0]        cmd_q   [NUM_PORTS];
  logic [DATA_W-1:0] op1_q   [NUM_PORTS];
  logic [DATA_W-1:0] op2_q   [NUM_PORTS];

  logic [IDX_W-1:0]  rr_ptr_q;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand_idx;
  int                cand;

  logic              exec_valid_q;
  logic [IDX_W-1:0]  exec_idx_q;

  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   alu_sum;
  logic [1:0]        alu_resp;
  logic [DATA_W-1:0] alu_data;

  // Round-robin: rr_ptr_q is the first port searched, i.e. last granted + 1.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IDX_W'(cand);
      if (!grant_valid && state_q[cand_idx] == PENDING) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      case (state_q[p])
        IDLE:    if (req_cmd_in[4*p +: 4] != CMD_NOP) state_d[p] = OP2;
        OP2:     state_d[p] = PENDING;
        PENDING: if (grant_valid && grant_idx == IDX_W'(p)) state_d[p] = EXEC;
        EXEC:    state_d[p] = IDLE;
        default: state_d[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= IDLE;
        cmd_q[p]   <= '0;
        op1_q[p]   <= '0;
        op2_q[p]   <= '0;
      end
      rr_ptr_q     <= '0;
      exec_valid_q <= 1'b0;
      exec_idx_q   <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= state_d[p];
        if (state_q[p] == IDLE && req_cmd_in[4*p +: 4] != CMD_NOP) begin
          cmd_q[p] <= req_cmd_in[4*p +: 4];
          op1_q[p] <= req_data_in[DATA_W*p +: DATA_W];
        end
        if (state_q[p] == OP2) op2_q[p] <= req_data_in[DATA_W*p +: DATA_W];
      end
      exec_valid_q <= grant_valid;
      if (grant_valid) begin
        exec_idx_q <= grant_idx;
        rr_ptr_q   <= (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Only one port can be in EXEC per cycle, so its operands feed the shared ALU.
  always_comb begin
    alu_cmd = '0;
    alu_a   = '0;
    alu_b   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (exec_idx_q == IDX_W'(p)) begin
        alu_cmd = cmd_q[p];
        alu_a   = op1_q[p];
        alu_b   = op2_q[p];
      end
    end
  end

  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    alu_resp = RESP_INV;
    alu_data = '0;
    case (alu_cmd)
      CMD_ADD: begin
        if (alu_sum[DATA_W]) begin
          alu_resp = RESP_OVF;
        end else begin
          alu_resp = RESP_OK;
          alu_data = alu_sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (alu_b > alu_a) begin
          alu_resp = RESP_OVF;
        end else begin
          alu_resp = RESP_OK;
          alu_data = alu_a - alu_b;
        end
      end
`ifdef CALC_SHIFT_EN
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = alu_a << alu_b[SH_W-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = alu_a >> alu_b[SH_W-1:0];
      end
`endif
      default: begin
        alu_resp = RESP_INV;
        alu_data = '0;
      end
    endcase
  end

  // Responses are single-cycle pulses; every other port reads zero.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      out_resp <= '0;
      out_data <= '0;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (exec_valid_q && exec_idx_q == IDX_W'(p)) begin
          out_resp[2*p +: 2]           <= alu_resp;
          out_data[DATA_W*p +: DATA_W] <= alu_data;
        end
      end
    end
  end

endmodule
